// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath enables. A shared wait
// counter bounds memory stalls in FETCH and MEM; expiry parks in ERR.
module cpu_ctrl_fsm #(
    parameter int unsigned MEM_TO = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_alu,
    input  logic       op_setf,
    input  logic       op_load,
    input  logic       op_store,
    input  logic       op_branch,
    input  logic [3:0] cond,
    input  logic       op_halt,
    input  logic [4:0] flags_q,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_wr,
    output logic       wb_sel_mem,
    output logic       flag_en,
    output logic       branch_taken,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cond_true;
    logic       is_mem_op;

    assign is_mem_op = op_load | op_store;

    // Branch condition evaluated against the registered flags {N,Z,F,L,C}
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true = flags_q[3];
            4'h1: cond_true = ~flags_q[3];
            4'h2: cond_true = flags_q[0];
            4'h3: cond_true = ~flags_q[0];
            4'h4: cond_true = flags_q[1];
            4'h5: cond_true = ~flags_q[1];
            4'h6: cond_true = flags_q[4];
            4'h7: cond_true = ~flags_q[4];
            4'h8: cond_true = flags_q[2];
            4'h9: cond_true = ~flags_q[2];
            4'hA: cond_true = ~flags_q[1] & ~flags_q[3];
            4'hB: cond_true = flags_q[1] | flags_q[3];
            4'hC: cond_true = ~flags_q[4] & ~flags_q[3];
            4'hD: cond_true = flags_q[4] | flags_q[3];
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Next state and memory wait counter; counter clears on any state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else                    state_d = op_load ? S_WB : S_FETCH;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: state_d = op_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op_branch)      state_d = S_FETCH;
                else if (is_mem_op) state_d = S_MEM;
                else                state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State and counter registers, asynchronously reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath enables decoded from state and inputs, forced low during reset
    always_comb begin
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ir_en        = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_wr       = 1'b0;
        wb_sel_mem   = 1'b0;
        flag_en      = 1'b0;
        branch_taken = 1'b0;
        err          = 1'b0;
        state_dbg    = reset ? S_START : state_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    ir_en  = mem_ready;
                end
                S_EXEC: begin
                    if (op_branch) begin
                        branch_taken = cond_true;
                        pc_load      = cond_true;
                        pc_inc       = ~cond_true;
                    end else if (!is_mem_op) begin
                        reg_wr  = op_alu;
                        flag_en = op_alu & op_setf;
                        pc_inc  = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_rd = op_load;
                    mem_wr = ~op_load;
                    pc_inc = ~op_load & mem_ready;
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    wb_sel_mem = 1'b1;
                    pc_inc     = 1'b1;
                end
                S_ERR:   err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
